// File: rtl/approx_add_pkg.sv
// Shared types and elaboration helpers for the pipelined approximate adder.
package approx_add_pkg;

   // Per-beat approximation mode; the reserved code behaves as exact addition.
   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_LOA   = 2'd1,
      MODE_TRUNC = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   // Number of pipeline stages: one SEG-bit slice per stage.
   function automatic int nseg_f(input int w, input int seg);
      return w / seg;
   endfunction

   // Legal parameter set: at least 2 bits, whole segments, approximated part below MSB.
   function automatic bit params_ok_f(input int w, input int seg, input int k);
      return (w >= 2) && (seg >= 1) && ((w % seg) == 0) && (k >= 0) && (k < w);
   endfunction

endpackage

// File: rtl/approx_add_seg.sv
// Combinational SEG-bit slice computing the approximate and the exact sum bits
// for absolute bit positions [BASE +: SEG], each with its own carry chain.
module approx_add_seg
   import approx_add_pkg::*;
#(
   parameter int SEG  = 4,
   parameter int BASE = 0,
   parameter int K    = 3
) (
   input  logic [1:0]     mode,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ca_in,
   input  logic           ce_in,
   output logic [SEG-1:0] sa,
   output logic [SEG-1:0] se,
   output logic           ca_out,
   output logic           ce_out
);

   logic [SEG:0] ca_c;
   logic [SEG:0] ce_c;
   logic         is_loa;
   logic         is_trunc;
   logic         unused_mode;

   assign is_loa      = (mode == MODE_LOA);
   assign is_trunc    = (mode == MODE_TRUNC);
   // Slices entirely above K never look at the mode.
   assign unused_mode = is_loa ^ is_trunc;

   assign ca_c[0] = ca_in;
   assign ce_c[0] = ce_in;

   for (genvar j = 0; j < SEG; j++) begin : g_bit
      localparam int I = BASE + j;
      logic fa_sum;
      logic fa_carry;

      assign fa_sum   = a[j] ^ b[j] ^ ca_c[j];
      assign fa_carry = (a[j] & b[j]) | (ca_c[j] & (a[j] ^ b[j]));

      // Exact shadow path: plain ripple carry regardless of mode.
      assign se[j]     = a[j] ^ b[j] ^ ce_c[j];
      assign ce_c[j+1] = (a[j] & b[j]) | (ce_c[j] & (a[j] ^ b[j]));

      if (I < K) begin : g_apx
         // Approximated LSB: OR (LOA), zero (TRUNC) or full add (EXACT/reserved).
         assign sa[j] = is_loa ? (a[j] | b[j]) : (is_trunc ? 1'b0 : fa_sum);
         if (I == K - 1) begin : g_top
            // LOA injects a[K-1]&b[K-1] as the carry into bit K; TRUNC injects none.
            assign ca_c[j+1] = is_loa ? (a[j] & b[j]) : (is_trunc ? 1'b0 : fa_carry);
         end else begin : g_low
            // Below K-1 the carry is discarded in both approximate modes.
            assign ca_c[j+1] = (is_loa | is_trunc) ? 1'b0 : fa_carry;
         end
      end else begin : g_full
         assign sa[j]     = fa_sum;
         assign ca_c[j+1] = fa_carry;
      end
   end

   assign ca_out = ca_c[SEG];
   assign ce_out = ce_c[SEG];

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined unsigned approximate adder with exact shadow sum, valid/ready
// handshake and a saturating mismatch counter.
//
// Handshake: a beat is accepted on in_valid & in_ready and retires on
// out_valid & out_ready. The pipeline stalls globally while out_valid is high
// and out_ready is low; every register holds and in_ready is low, so an
// offered beat is neither accepted nor consumed until the stall clears.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int W     = 8,
   parameter int SEG   = 4,
   parameter int K     = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       out_sum,
   output logic [W:0]       out_exact,
   output logic             out_mismatch,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] mismatch_cnt
);

   localparam int NSEG = nseg_f(W, SEG);

   if (!params_ok_f(W, SEG, K)) begin : g_bad_params
      $error("approx_add_pipe: illegal W/SEG/K combination");
   end

   logic stall;

   // Input register: holds the accepted beat before the first slice.
   logic             ip_vld_q, ip_vld_d;
   logic [W-1:0]     ip_a_q, ip_a_d;
   logic [W-1:0]     ip_b_q, ip_b_d;
   logic [1:0]       ip_mode_q, ip_mode_d;

   // Stage registers: stage s holds sum bits [0 .. (s+1)*SEG-1] plus carries.
   logic [NSEG-1:0]        vld_q, vld_d;
   logic [NSEG-1:0][W-1:0] a_q, a_d;
   logic [NSEG-1:0][W-1:0] b_q, b_d;
   logic [NSEG-1:0][1:0]   mode_q, mode_d;
   logic [NSEG-1:0][W-1:0] sa_q, sa_d;
   logic [NSEG-1:0][W-1:0] se_q, se_d;
   logic [NSEG-1:0]        ca_q, ca_d;
   logic [NSEG-1:0]        ce_q, ce_d;
   logic                   mm_q, mm_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Per-stage inputs (previous register) and slice outputs.
   logic [NSEG-1:0]          src_vld;
   logic [NSEG-1:0][W-1:0]   src_a, src_b, src_sa, src_se;
   logic [NSEG-1:0][1:0]     src_mode;
   logic [NSEG-1:0]          src_ca, src_ce;
   logic [NSEG-1:0][SEG-1:0] sl_sa, sl_se;
   logic [NSEG-1:0]          sl_ca, sl_ce;
   logic                     unused_tail;

   for (genvar s = 0; s < NSEG; s++) begin : g_stage
      if (s == 0) begin : g_first
         assign src_vld[s]  = ip_vld_q;
         assign src_a[s]    = ip_a_q;
         assign src_b[s]    = ip_b_q;
         assign src_mode[s] = ip_mode_q;
         assign src_sa[s]   = '0;
         assign src_se[s]   = '0;
         assign src_ca[s]   = 1'b0;
         assign src_ce[s]   = 1'b0;
      end else begin : g_next
         assign src_vld[s]  = vld_q[s-1];
         assign src_a[s]    = a_q[s-1];
         assign src_b[s]    = b_q[s-1];
         assign src_mode[s] = mode_q[s-1];
         assign src_sa[s]   = sa_q[s-1];
         assign src_se[s]   = se_q[s-1];
         assign src_ca[s]   = ca_q[s-1];
         assign src_ce[s]   = ce_q[s-1];
      end

      approx_add_seg #(
         .SEG  (SEG),
         .BASE (s * SEG),
         .K    (K)
      ) u_seg (
         .mode   (src_mode[s]),
         .a      (SEG'(src_a[s] >> (s * SEG))),
         .b      (SEG'(src_b[s] >> (s * SEG))),
         .ca_in  (src_ca[s]),
         .ce_in  (src_ce[s]),
         .sa     (sl_sa[s]),
         .se     (sl_se[s]),
         .ca_out (sl_ca[s]),
         .ce_out (sl_ce[s])
      );
   end

   // Operands and mode leave the last stage unconsumed.
   assign unused_tail = ^{a_q[NSEG-1], b_q[NSEG-1], mode_q[NSEG-1]};

   assign out_valid    = vld_q[NSEG-1];
   assign stall        = out_valid & ~out_ready;
   assign in_ready     = ~stall;
   assign out_sum      = {ca_q[NSEG-1], sa_q[NSEG-1]};
   assign out_exact    = {ce_q[NSEG-1], se_q[NSEG-1]};
   assign out_mismatch = mm_q;
   assign mismatch_cnt = cnt_q;

   // Pipeline advance: everything shifts one stage unless globally stalled.
   always_comb begin
      ip_vld_d  = ip_vld_q;
      ip_a_d    = ip_a_q;
      ip_b_d    = ip_b_q;
      ip_mode_d = ip_mode_q;
      vld_d     = vld_q;
      a_d       = a_q;
      b_d       = b_q;
      mode_d    = mode_q;
      sa_d      = sa_q;
      se_d      = se_q;
      ca_d      = ca_q;
      ce_d      = ce_q;
      mm_d      = mm_q;
      if (!stall) begin
         ip_vld_d  = in_valid;
         ip_a_d    = in_a;
         ip_b_d    = in_b;
         ip_mode_d = in_mode;
         for (int s = 0; s < NSEG; s++) begin
            vld_d[s]               = src_vld[s];
            a_d[s]                 = src_a[s];
            b_d[s]                 = src_b[s];
            mode_d[s]              = src_mode[s];
            sa_d[s]                = src_sa[s];
            se_d[s]                = src_se[s];
            sa_d[s][s*SEG +: SEG]  = sl_sa[s];
            se_d[s][s*SEG +: SEG]  = sl_se[s];
            ca_d[s]                = sl_ca[s];
            ce_d[s]                = sl_ce[s];
         end
         mm_d = ({sl_ca[NSEG-1], sa_d[NSEG-1]} != {sl_ce[NSEG-1], se_d[NSEG-1]});
      end
   end

   // Mismatch counter: clear wins over a counted retirement; saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_stats) begin
         cnt_d = '0;
      end else if (out_valid && out_ready && mm_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; reset discards every in-flight beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ip_vld_q  <= 1'b0;
         ip_a_q    <= '0;
         ip_b_q    <= '0;
         ip_mode_q <= '0;
         vld_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= '0;
         sa_q      <= '0;
         se_q      <= '0;
         ca_q      <= '0;
         ce_q      <= '0;
         mm_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         ip_vld_q  <= ip_vld_d;
         ip_a_q    <= ip_a_d;
         ip_b_q    <= ip_b_d;
         ip_mode_q <= ip_mode_d;
         vld_q     <= vld_d;
         a_q       <= a_d;
         b_q       <= b_d;
         mode_q    <= mode_d;
         sa_q      <= sa_d;
         se_q      <= se_d;
         ca_q      <= ca_d;
         ce_q      <= ce_d;
         mm_q      <= mm_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench: directed cases on a W=8/K=3/CNT_W=4 instance, random
// streams on that instance and on a W=16/K=0 instance, against an arithmetic model.
module tb_approx_add_pipe;

   localparam int W0 = 8;
   localparam int K0 = 3;
   localparam int C0 = 4;
   localparam int W1 = 16;
   localparam int K1 = 0;
   localparam int C1 = 16;
   localparam int NBEATS = 10000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          v0, ir0, ov0, or0, mm0, clr0;
   logic [W0-1:0] a0, b0;
   logic [1:0]    m0;
   logic [W0:0]   s0, e0;
   logic [C0-1:0] cnt0;

   logic          v1, ir1, ov1, or1, mm1, clr1;
   logic [W1-1:0] a1, b1;
   logic [1:0]    m1;
   logic [W1:0]   s1, e1;
   logic [C1-1:0] cnt1;

   approx_add_pipe #(.W(W0), .SEG(4), .K(K0), .CNT_W(C0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_a(a0), .in_b(b0),
      .in_mode(m0), .out_valid(ov0), .out_ready(or0), .out_sum(s0), .out_exact(e0),
      .out_mismatch(mm0), .clr_stats(clr0), .mismatch_cnt(cnt0));

   approx_add_pipe #(.W(W1), .SEG(4), .K(K1), .CNT_W(C1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
      .in_mode(m1), .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_exact(e1),
      .out_mismatch(mm1), .clr_stats(clr1), .mismatch_cnt(cnt1));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: the high part is an ordinary sum of the operands shifted right by K.
   function automatic logic [63:0] ref_sum(input int k, input logic [63:0] a,
                                           input logic [63:0] b, input logic [1:0] m);
      logic [63:0] hi;
      logic [63:0] lo_mask;
      if (k == 0 || m == 2'd0 || m == 2'd3) return a + b;
      lo_mask = (64'(1) << k) - 64'(1);
      hi = (a >> k) + (b >> k);
      if (m == 2'd1) return ((hi + (((a >> (k - 1)) & (b >> (k - 1))) & 64'(1))) << k) | ((a | b) & lo_mask);
      return hi << k;
   endfunction

   // Scoreboards: expected results queued at acceptance, popped at retirement.
   logic [63:0] exp_sum0_q[$], exp_ex0_q[$], exp_sum1_q[$], exp_ex1_q[$];
   logic [63:0] es0, ee0, es1, ee1;
   int acc0 = 0, ret0 = 0, mcnt0 = 0;
   int acc1 = 0, ret1 = 0, mcnt1 = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_sum0_q.delete(); exp_ex0_q.delete(); mcnt0 = 0;
      end else begin
         check("cnt0", 64'(cnt0), 64'(mcnt0));
         check("in_ready0", 64'(ir0), 64'(!(ov0 && !or0)));
         if (ov0 && or0) begin
            check("sb0_nonempty", 64'(exp_sum0_q.size() != 0), 64'(1));
            if (exp_sum0_q.size() != 0) begin
               es0 = exp_sum0_q.pop_front(); ee0 = exp_ex0_q.pop_front();
               check("sum0", 64'(s0), es0);
               check("exact0", 64'(e0), ee0);
               check("mm0", 64'(mm0), 64'(es0 != ee0));
               ret0++;
               if (es0 != ee0 && mcnt0 < (1 << C0) - 1) mcnt0++;
            end
         end
         if (clr0) mcnt0 = 0;
         if (v0 && ir0) begin
            exp_sum0_q.push_back(ref_sum(K0, 64'(a0), 64'(b0), m0));
            exp_ex0_q.push_back(64'(a0) + 64'(b0));
            acc0++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         exp_sum1_q.delete(); exp_ex1_q.delete(); mcnt1 = 0;
      end else begin
         check("cnt1", 64'(cnt1), 64'(mcnt1));
         check("in_ready1", 64'(ir1), 64'(!(ov1 && !or1)));
         if (ov1 && or1) begin
            check("sb1_nonempty", 64'(exp_sum1_q.size() != 0), 64'(1));
            if (exp_sum1_q.size() != 0) begin
               es1 = exp_sum1_q.pop_front(); ee1 = exp_ex1_q.pop_front();
               check("sum1", 64'(s1), es1);
               check("exact1", 64'(e1), ee1);
               check("mm1", 64'(mm1), 64'(es1 != ee1));
               ret1++;
               if (es1 != ee1 && mcnt1 < 65535) mcnt1++;
            end
         end
         if (clr1) mcnt1 = 0;
         if (v1 && ir1) begin
            exp_sum1_q.push_back(ref_sum(K1, 64'(a1), 64'(b1), m1));
            exp_ex1_q.push_back(64'(a1) + 64'(b1));
            acc1++;
         end
      end
   end

   // One beat on dut0 with out_ready high; result must appear exactly 2 cycles later.
   task automatic lat_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] m, input logic [8:0] exp_s,
                           input logic [8:0] exp_e, input logic exp_mm);
      @(posedge clk); #1;
      v0 = 1'b1; a0 = a; b0 = b; m0 = m; or0 = 1'b1;
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk); check({tag, "_lat0"}, 64'(ov0), 64'(0));
      @(negedge clk); check({tag, "_lat1"}, 64'(ov0), 64'(0));
      @(negedge clk); check({tag, "_valid"}, 64'(ov0), 64'(1));
      check({tag, "_sum"}, 64'(s0), 64'(exp_s));
      check({tag, "_exact"}, 64'(e0), 64'(exp_e));
      check({tag, "_mm"}, 64'(mm0), 64'(exp_mm));
   endtask

   // Random stream on dut0; an unaccepted beat is held until it is taken.
   task automatic rand_drive0();
      int cyc;
      int last;
      int start;
      cyc = 0; start = acc0; last = acc0;
      while (acc0 - start < NBEATS && cyc < 30000) begin
         @(posedge clk); #1;
         cyc++;
         if (!(v0 && acc0 == last)) begin
            v0 = ($urandom_range(3) != 0);
            a0 = W0'($urandom); b0 = W0'($urandom); m0 = 2'($urandom_range(3));
         end
         last = acc0;
         or0  = ($urandom_range(3) != 0);
         clr0 = ($urandom_range(63) == 0);
      end
      check("rand0_done", 64'(acc0 - start >= NBEATS), 64'(1));
      @(posedge clk); #1;
      v0 = 1'b0; or0 = 1'b1; clr0 = 1'b0;
   endtask

   task automatic rand_drive1();
      int cyc;
      int last;
      int start;
      cyc = 0; start = acc1; last = acc1;
      while (acc1 - start < NBEATS && cyc < 30000) begin
         @(posedge clk); #1;
         cyc++;
         if (!(v1 && acc1 == last)) begin
            v1 = ($urandom_range(3) != 0);
            a1 = W1'($urandom); b1 = W1'($urandom); m1 = 2'($urandom_range(3));
         end
         last = acc1;
         or1  = ($urandom_range(3) != 0);
         clr1 = ($urandom_range(63) == 0);
      end
      check("rand1_done", 64'(acc1 - start >= NBEATS), 64'(1));
      @(posedge clk); #1;
      v1 = 1'b0; or1 = 1'b1; clr1 = 1'b0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int presented;
      int start_acc;
      int start_ret;
      rst = 1'b1;
      v0 = 1'b0; a0 = '0; b0 = '0; m0 = '0; or0 = 1'b1; clr0 = 1'b0;
      v1 = 1'b0; a1 = '0; b1 = '0; m1 = '0; or1 = 1'b1; clr1 = 1'b0;

      // Clock/reset phase.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(ov0), 64'(0));
      check("rst_out_sum", 64'(s0), 64'(0));
      check("rst_out_exact", 64'(e0), 64'(0));
      check("rst_mismatch", 64'(mm0), 64'(0));
      check("rst_cnt", 64'(cnt0), 64'(0));
      check("rst_in_ready", 64'(ir0), 64'(1));
      rst = 1'b0;

      // Small operands in each mode, then the all-ones corner.
      lat_beat("x07_exact", 8'h07, 8'h01, 2'd0, 9'h008, 9'h008, 1'b0);
      lat_beat("x07_loa",   8'h07, 8'h01, 2'd1, 9'h007, 9'h008, 1'b1);
      lat_beat("x07_trunc", 8'h07, 8'h01, 2'd2, 9'h000, 9'h008, 1'b1);
      lat_beat("xff_exact", 8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'h1FE, 1'b0);
      lat_beat("xff_loa",   8'hFF, 8'hFF, 2'd1, 9'h1FF, 9'h1FE, 1'b1);
      lat_beat("xff_trunc", 8'hFF, 8'hFF, 2'd2, 9'h1F0, 9'h1FE, 1'b1);
      lat_beat("xff_rsvd",  8'hFF, 8'hFF, 2'd3, 9'h1FE, 9'h1FE, 1'b0);

      // Back-to-back stream of 16 beats with out_ready low on cycles 5..8.
      @(posedge clk); #1;
      start_acc = acc0; start_ret = ret0; presented = 0; c = 0;
      while (acc0 - start_acc < 16 && c < 200) begin
         or0 = !(c >= 5 && c <= 8);
         if (acc0 - start_acc == presented) begin
            v0 = 1'b1; a0 = 8'($urandom); b0 = 8'($urandom); m0 = 2'($urandom_range(3));
            presented++;
         end
         @(posedge clk); #1;
         c++;
      end
      v0 = 1'b0; or0 = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("stream_accepted", 64'(acc0 - start_acc), 64'(16));
      check("stream_retired", 64'(ret0 - start_ret), 64'(16));
      check("stream_drained", 64'(exp_sum0_q.size()), 64'(0));

      // Saturation: 20 mismatching LOA beats into a 4-bit counter.
      clr0 = 1'b1;
      @(posedge clk); #1;
      clr0 = 1'b0;
      v0 = 1'b1; a0 = 8'h07; b0 = 8'h01; m0 = 2'd1;
      repeat (20) @(posedge clk);
      #1;
      v0 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("cnt_saturated", 64'(cnt0), 64'(15));

      // Clear coinciding with a mismatching handshake.
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 8'h07; b0 = 8'h01; m0 = 2'd1;
      @(posedge clk); #1;
      v0 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      clr0 = 1'b1;
      @(negedge clk);
      check("clr_hs_valid", 64'(ov0), 64'(1));
      check("clr_hs_mm", 64'(mm0), 64'(1));
      @(posedge clk); #1;
      clr0 = 1'b0;
      @(negedge clk);
      check("cnt_cleared", 64'(cnt0), 64'(0));

      // One counted mismatch, then reset with two beats in flight.
      lat_beat("pre_rst", 8'h07, 8'h01, 2'd2, 9'h000, 9'h008, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_cnt", 64'(cnt0), 64'(1));
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; m0 = 2'd1;
      @(posedge clk);
      @(posedge clk); #1;
      v0 = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_valid_before", 64'(ov0), 64'(1));
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 64'(ov0), 64'(0));
      check("rst_mid_cnt", 64'(cnt0), 64'(0));
      check("rst_mid_sum", 64'(s0), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      lat_beat("post_rst", 8'hA5, 8'h3C, 2'd0, 9'h0E1, 9'h0E1, 1'b0);
      @(posedge clk);

      // Random streams on both configurations in parallel.
      fork
         rand_drive0();
         rand_drive1();
      join
      repeat (20) @(posedge clk);
      #1;
      check("rand0_drained", 64'(exp_sum0_q.size()), 64'(0));
      check("rand1_drained", 64'(exp_sum1_q.size()), 64'(0));
      check("rand0_balance", 64'(ret0), 64'(acc0 - 2));
      check("rand1_balance", 64'(ret1), 64'(acc1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
